// File: rtl/rom_player_pkg.sv
// Shared types and default sizing for the ROM sample player.
package rom_player_pkg;

    typedef enum logic {IDLE, PLAY} play_state_t;

    localparam int DEFAULT_DATA_W    = 24;
    localparam int DEFAULT_ADDR_W    = 16;
    localparam int DEFAULT_LAST_ADDR = 47999;
    localparam int DEFAULT_NCH       = 2;

endpackage

// File: rtl/sample_addr_counter.sv
// ROM address counter: synchronous clear, increment, wraps to 0 after LAST_ADDR.
module sample_addr_counter #(
    parameter int ADDR_W    = 16,
    parameter int LAST_ADDR = 47999
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr,
    output logic              wrap
);

    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W-1:0] addr_next;

    assign wrap = (addr_reg == ADDR_W'(LAST_ADDR));
    assign addr = addr_reg;

    // Clear wins over increment so a restart always lands on sample 0.
    always_comb begin
        addr_next = addr_reg;
        if (clr) begin
            addr_next = '0;
        end else if (inc) begin
            addr_next = wrap ? '0 : addr_reg + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_reg <= '0;
        end else begin
            addr_reg <= addr_next;
        end
    end

endmodule

// File: rtl/rom_sample_player.sv
// ROM sample player: start/stop FSM, one-shot or looping playback, ROM/mic output mux.
// Optional ROM attenuation is enabled by defining ROM_ATTEN_EN (adds the atten port).
module rom_sample_player
    import rom_player_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int ADDR_W    = DEFAULT_ADDR_W,
    parameter int LAST_ADDR = DEFAULT_LAST_ADDR,
    parameter int NCH       = DEFAULT_NCH
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  loop_en,
    input  logic                  sel_rom,
    input  logic                  advance,
    input  logic [NCH*DATA_W-1:0] mic_in,
    input  logic [DATA_W-1:0]     rom_q,
`ifdef ROM_ATTEN_EN
    input  logic [2:0]            atten,
`endif
    output logic [ADDR_W-1:0]     rom_addr,
    output logic [NCH*DATA_W-1:0] aud_out,
    output logic                  playing,
    output logic                  done
);

    play_state_t state_reg;
    play_state_t state_next;
    logic        done_reg;
    logic        done_next;
    logic        cnt_clr;
    logic        cnt_inc;
    logic        cnt_wrap;

    sample_addr_counter #(
        .ADDR_W    (ADDR_W),
        .LAST_ADDR (LAST_ADDR)
    ) u_addr (
        .clk  (CLOCK_50),
        .rst  (reset),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .addr (rom_addr),
        .wrap (cnt_wrap)
    );

    // Priority: start, then stop, then advance; IDLE ignores stop and advance.
    always_comb begin
        state_next = state_reg;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        done_next  = 1'b0;
        if (start) begin
            state_next = PLAY;
            cnt_clr    = 1'b1;
        end else if (state_reg == PLAY) begin
            if (stop) begin
                state_next = IDLE;
                cnt_clr    = 1'b1;
                done_next  = 1'b1;
            end else if (advance) begin
                if (cnt_wrap && !loop_en) begin
                    state_next = IDLE;
                    cnt_clr    = 1'b1;
                    done_next  = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= done_next;
        end
    end

    assign playing = (state_reg == PLAY);
    assign done    = done_reg;

    logic [DATA_W-1:0] rom_shaped;
`ifdef ROM_ATTEN_EN
    assign rom_shaped = $signed(rom_q) >>> atten;
`else
    assign rom_shaped = rom_q;
`endif

    logic rom_active;
    assign rom_active = sel_rom & playing;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            assign aud_out[gi*DATA_W +: DATA_W] =
                rom_active ? rom_shaped : mic_in[gi*DATA_W +: DATA_W];
        end
    endgenerate

endmodule
